adc128s022_spi_slave: RTL
=========================

ADC128S022_SPI_SLAVE -- requirements
Module: adc128s022_spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops per SPI input (legal range 2..3).
REQ-002 SHALL have port i_Clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port i_Rst_L  input  1  asynchronous active-low reset.
REQ-004 SHALL have port i_SCLK  input  1  SPI clock from master, mode 0, asynchronous to i_Clk.
REQ-005 SHALL have port i_CS_N  input  1  active-low chip select, asynchronous.
REQ-006 SHALL have port i_DIN  input  1  MOSI, control byte MSB first.
REQ-007 SHALL have port i_Ch_Data  input  96  eight 12-bit channel samples; channel n at bits [12n+11:12n].
REQ-008 SHALL have port o_DOUT  output  1  MISO data.
REQ-009 SHALL have port o_DOUT_OE  output  1  MISO drive enable (1 when synchronized CS_N low).
REQ-010 SHALL have port o_Frame_DV  output  1  one-cycle pulse per completed 16-SCLK frame.
REQ-011 SHALL have port o_Frame_Addr  output  3  ADD2..ADD0 captured in the frame flagged by o_Frame_DV.
REQ-012 SHALL have port o_Cur_Addr  output  3  committed channel address used for the next conversion.

Function
REQ-013 SHALL synchronize i_SCLK, i_CS_N, i_DIN through SYNC_STAGES flops and detect SCLK rise/fall and CS_N fall/rise as one-cycle events.
REQ-014 SHALL require SCLK high and low phases of at least 4 i_Clk cycles; o_DOUT SHALL update no more than SYNC_STAGES+1 i_Clk cycles after the SCLK falling edge at the pin.
REQ-015 SHALL implement states IDLE (CS_N high), FRAME (CS_N low, counting SCLK rising edges 0..16).
REQ-016 Frame start event: CS_N falling edge, or 16th SCLK rising edge while CS_N stays low (continuous mode, CS_N tied low).
REQ-017 At frame start: latch i_Ch_Data slice of o_Cur_Addr into a 16-bit shift word {4'b0000, sample[11:0]}, clear rising-edge counter, drive o_DOUT = word[15] (0).
REQ-018 On SCLK rising edge n (1..8): sample DIN into control byte bit 8-n; rising edges 9..16 ignore DIN.
REQ-019 On SCLK falling edge following rising edge n (1..15): o_DOUT = word[15-n]; a falling edge with counter 0 SHALL NOT shift.
REQ-020 On 16th rising edge: o_Cur_Addr <= control[5:3]; o_Frame_Addr <= control[5:3]; o_Frame_DV pulses next cycle; new frame starts per REQ-016.
REQ-021 CS_N rising mid-frame: abort to IDLE; o_Cur_Addr updated to captured ADD bits only if at least 5 rising edges seen, else retained; no o_Frame_DV.
REQ-022 SCLK edges while CS_N high SHALL be ignored; o_DOUT = 0 and o_DOUT_OE = 0 in IDLE.
REQ-023 CS_N rise and SCLK edge in same cycle: CS_N rise wins.
REQ-024 Channel conversion is pipelined: data in frame k is the channel addressed in frame k-1; first frame after reset returns channel 0.

Reset
REQ-025 i_Rst_L low SHALL asynchronously force: state IDLE, counter 0, shift word 0, control byte 0, o_Cur_Addr 0, o_Frame_Addr 0, o_Frame_DV 0, o_DOUT 0, o_DOUT_OE 0.
REQ-026 CS_N synchronizer flops SHALL reset to 1 so CS_N held low through reset release yields a frame start once synchronized.
REQ-027 Reset asserted mid-frame SHALL discard the frame without o_Frame_DV.

Structure
REQ-028 Package adc128s022_pkg SHALL hold FRAME_BITS=16, DATA_BITS=12, LEAD_ZEROS=4, NUM_CH=8, ADDR_LSB=3, ADDR_MSB=5.
REQ-029 Sub-module sync_edge_det (synchronizer plus rise/fall pulses, parameter SYNC_STAGES) SHALL be instantiated per SPI input.

Verification
REQ-030 Reset, CS_N low, 16 SCLKs at i_Clk/8, DIN byte 0x18, ch0=0xABC -> DOUT bits 0000_1010_1011_1100; o_Frame_DV once, o_Frame_Addr=3.
REQ-031 Second frame after REQ-030, ch3=0x5A5 -> DOUT 0x05A5; o_Cur_Addr=3.
REQ-032 CS_N tied low, 3 back-to-back frames addressing 7,2,5 with ch7=0xFFF, ch2=0x001 -> frames 2,3 return 0x0FFF, 0x0001; three o_Frame_DV pulses.
REQ-033 CS_N rises after 4 rising edges with DIN 0x38 -> no o_Frame_DV, o_Cur_Addr unchanged; after 6 edges -> o_Cur_Addr=7.
REQ-034 i_Rst_L asserted at SCLK edge 10 -> all outputs 0 immediately; next frame returns channel 0 data.
REQ-035 SCLK toggling with CS_N high -> o_DOUT_OE=0, no o_Frame_DV, o_Cur_Addr unchanged.

Source files
------------

// File: rtl/adc128s022_pkg.sv
// ADC128S022 SPI slave model: shared constants, types and helpers.
// Frame layout is 4 leading zeros followed by a 12-bit sample.
package adc128s022_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam int LEAD_ZEROS = 4;
  localparam int NUM_CH     = 8;
  localparam int ADDR_LSB   = 3;
  localparam int ADDR_MSB   = 5;
  localparam int CNT_W      = 5;
  localparam int CH_W       = NUM_CH * DATA_BITS;

  typedef enum logic {
    ST_IDLE,
    ST_FRAME
  } state_t;

  typedef logic [ADDR_MSB-ADDR_LSB:0] addr_t;

  function automatic logic [FRAME_BITS-1:0] load_word(
    input logic [CH_W-1:0] ch,
    input addr_t           a
  );
    return {{LEAD_ZEROS{1'b0}},
            ch[int'(a)*DATA_BITS +: DATA_BITS]};
  endfunction

endpackage

// File: rtl/adc128s022_spi_slave_if.sv
// SPI pin bundle between an SPI master and the ADC slave model.
// Master drives clock, select and MOSI; slave returns MISO and its enable.
interface adc128s022_spi_slave_if;
  logic sclk;
  logic cs_n;
  logic din;
  logic dout;
  logic dout_oe;

  modport master (
    output sclk, cs_n, din,
    input  dout, dout_oe
  );

  modport slave (
    input  sclk, cs_n, din,
    output dout, dout_oe
  );
endinterface

// File: rtl/adc128s022_spi_slave_sync_edge_det.sv
// Multi-flop synchronizer with one-cycle rise/fall pulses.
// RST_VAL sets the idle level assumed while in reset.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/adc128s022_spi_slave.sv
// ADC128S022 behavioural SPI slave: 16-SCLK frames, pipelined channel
// select, continuous mode when CS_N is held low.
module adc128s022_spi_slave
  import adc128s022_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic            i_Clk,
  input  logic            i_Rst_L,
  input  logic            i_SCLK,
  input  logic            i_CS_N,
  input  logic            i_DIN,
  input  logic [CH_W-1:0] i_Ch_Data,
  output logic            o_DOUT,
  output logic            o_DOUT_OE,
  output logic            o_Frame_DV,
  output addr_t           o_Frame_Addr,
  output addr_t           o_Cur_Addr
);

  logic sclk_q, sclk_rise, sclk_fall;
  logic cs_q, cs_rise, cs_fall;
  logic din_q, din_rise, din_fall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(i_Clk), .rst_n(i_Rst_L), .d(i_SCLK),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(i_Clk), .rst_n(i_Rst_L), .d(i_CS_N),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din (
    .clk(i_Clk), .rst_n(i_Rst_L), .d(i_DIN),
    .q(din_q), .rise(din_rise), .fall(din_fall)
  );

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [FRAME_BITS-1:0] word_q;
  logic [7:0]            ctrl_q;

  logic  live, start, sample, shift, commit, abort;
  addr_t ctrl_addr, load_addr;

  logic unused_ok;
  assign unused_ok = ^{sclk_q, cs_q, din_rise, din_fall, ctrl_q};

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (cs_fall) state_d = ST_FRAME;
      ST_FRAME: if (cs_rise) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // CS_N rise masks any SCLK edge seen in the same cycle.
  always_comb begin
    live      = (state_q == ST_FRAME) && !cs_rise;
    commit    = live && sclk_rise
             && (cnt_q == CNT_W'(FRAME_BITS - 1));
    start     = ((state_q == ST_IDLE) && cs_fall) || commit;
    sample    = live && sclk_rise && (cnt_q < CNT_W'(8));
    shift     = live && sclk_fall && (cnt_q != '0);
    abort     = (state_q == ST_FRAME) && cs_rise;
    ctrl_addr = ctrl_q[ADDR_MSB:ADDR_LSB];
    load_addr = commit ? ctrl_addr : o_Cur_Addr;
  end

  assign o_DOUT_OE = (state_q == ST_FRAME);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_q        <= '0;
      word_q       <= '0;
      ctrl_q       <= '0;
      o_DOUT       <= 1'b0;
      o_Frame_DV   <= 1'b0;
      o_Frame_Addr <= '0;
      o_Cur_Addr   <= '0;
    end else begin
      o_Frame_DV <= commit;
      if (commit) begin
        o_Cur_Addr   <= ctrl_addr;
        o_Frame_Addr <= ctrl_addr;
      end else if (abort && cnt_q >= CNT_W'(ADDR_MSB)) begin
        o_Cur_Addr <= ctrl_addr;
      end
      if (start) begin
        word_q <= load_word(i_Ch_Data, load_addr);
        cnt_q  <= '0;
        ctrl_q <= '0;
        o_DOUT <= 1'b0;
      end else if (abort) begin
        cnt_q  <= '0;
        o_DOUT <= 1'b0;
      end else begin
        if (live && sclk_rise) cnt_q <= cnt_q + 1'b1;
        if (sample) ctrl_q[~cnt_q[2:0]] <= din_q;
        if (shift)  o_DOUT <= word_q[~cnt_q[3:0]];
      end
    end
  end

endmodule
